branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer end of the branch predictor interface. Holds predictions issued at decode (prediction, branch_addr, PC) in a small in-order queue. At mem stage, compares each against the actual outcome and produces the pipeline flush/redirect. Returns the training pulse (actual_branch_decision plus branch_mem_sig equivalent) to the predictor.

Parameters:
DEPTH, 4, maximum in-flight unresolved branches (power of two, >=2)
ADDR_W, 32, PC/target width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pred_valid  input  1  branch decoded this cycle (branch_decode_sig)
pred_taken  input  1  predictor's decision (prediction)
pred_pc  input  ADDR_W  PC of the branch
pred_target  input  ADDR_W  predicted target (branch_addr)
resolve_valid  input  1  oldest branch resolved this cycle (branch_mem_sig)
resolve_taken  input  1  actual outcome
resolve_target  input  ADDR_W  computed taken target
flush  output  1  one-cycle pulse: squash younger instructions
redirect_pc  output  ADDR_W  fetch PC to use when flush=1
update_valid  output  1  one-cycle training pulse to predictor
update_taken  output  1  actual outcome for training (actual_branch_decision)
update_pc  output  ADDR_W  PC of the branch being trained
full  output  1  queue holds DEPTH entries
empty  output  1  queue holds 0 entries
err_overflow  output  1  sticky: push attempted while full
err_underflow  output  1  sticky: resolve while empty
resolved_cnt  output  16  resolved branches (BRU_STATS_EN only)
mispred_cnt  output  16  mispredictions (BRU_STATS_EN only)

Behaviour:
- Reset (async, rst_n=0): queue empty, rd/wr pointers 0, flush=0, redirect_pc=0, update_valid=0, update_taken=0, update_pc=0, full=0, empty=1, both err flags 0, counters 0.
- Queue entry: {pc, taken, target}. Circular buffer with log2(DEPTH)-bit pointers wrapping at DEPTH. An occupancy counter of log2(DEPTH)+1 bits drives full and empty.
- Push: pred_valid=1 and not full writes at wr_ptr at the clock edge.
- Pop: resolve_valid=1 and not empty reads the head combinationally and advances rd_ptr at the clock edge.
- Mispredict condition: (head.taken != resolve_taken) OR (head.taken=1 AND resolve_taken=1 AND head.target != resolve_target).
- Resolve outputs, registered (latency 1 cycle after the resolve_valid edge):
  - update_valid=1, update_taken=resolve_taken, update_pc=head.pc.
  - On mispredict: flush=1.
  - redirect_pc = resolve_target if resolve_taken, else head.pc+4 (modulo 2^ADDR_W).
- Outputs return to 0 next cycle unless another resolve occurs. redirect_pc holds its last value.
- Mispredict clears the queue at the same edge: pointers and count reset, empty=1. Entries after the head are wrong-path.
- Simultaneous push and mispredict resolve: the push is discarded, and the queue is empty after the edge.
- Simultaneous push and correct resolve: occupancy unchanged. This is legal when full, and no overflow is flagged.
- Push while full without a pop: entry dropped, err_overflow set, held until reset.
- Resolve while empty: ignored (no update, no flush), err_underflow set, held until reset.
- If rst_n deasserts mid-operation, all in-flight entries are lost and no pending flush/update is emitted.

Optional Feature:
BRU_STATS_EN
- Defined: resolved_cnt increments on every accepted resolve; mispred_cnt increments on every flush. Both are 16-bit, saturate at 16'hFFFF, reset to 0.
- Undefined: counter registers are not built; resolved_cnt and mispred_cnt tied to 16'h0000.

Test Plan:
1. Push pc=0x84, taken=1, target=0x84; next cycle resolve taken=1, target=0x84 -> cycle after: update_valid=1, update_taken=1, update_pc=0x84, flush=0, empty=1.
2. Push pc=0x84, taken=1; resolve taken=0 -> flush=1, redirect_pc=0x88, update_taken=0. With BRU_STATS_EN: mispred_cnt=1, resolved_cnt=1.
3. Push pc=0x100, taken=0; resolve taken=1, target=0x200 -> flush=1, redirect_pc=0x200. Also push pc=0x104, taken=1, target=0x140 and resolve taken=1, target=0x180 -> flush=1, redirect_pc=0x180 (target mismatch).
4. DEPTH=4: push 4 entries -> full=1. 5th push alone -> err_overflow=1, count stays 4. Then push and correct resolve in the same cycle -> full stays 1, err_overflow unchanged.
5. Three entries queued; head mispredicts while pred_valid=1 -> flush=1, empty=1 next cycle, count=0. Later resolve -> err_underflow=1, no flush/update.
6. Two entries queued; assert rst_n=0 mid-cycle -> empty=1, flush=0, update_valid=0 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order branch prediction queue with mem-stage resolve, flush and training
//
// Holds predictions issued at decode and checks each one, oldest first, against
// the actual outcome at mem stage. A mispredict squashes the pipeline via flush
// and redirect_pc. Every accepted resolve emits a one-cycle training pulse.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   pred_valid/taken/pc/target         push of a decoded branch prediction
//   resolve_valid/taken/target         actual outcome of the oldest branch
//   flush, redirect_pc                 squash pulse and fetch PC to use with it
//   update_valid/taken/pc              training pulse back to the predictor
//   full, empty                        queue occupancy status
//   err_overflow, err_underflow        sticky protocol error flags
//   resolved_cnt, mispred_cnt          statistics counters
//
// Optional feature macro: BRU_STATS_EN builds saturating 16-bit counters for
// resolved branches and mispredictions; without it both outputs read zero.

module branch_resolve_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_pc,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              update_valid,
  output logic              update_taken,
  output logic [ADDR_W-1:0] update_pc,
  output logic              full,
  output logic              empty,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic [15:0]       resolved_cnt,
  output logic [15:0]       mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_W-1:0] pc_mem     [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];
  logic              taken_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] head_target;
  logic              head_taken;
  logic              pop;
  logic              mispred;
  logic              push_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign head_pc     = pc_mem[rd_ptr];
  assign head_target = target_mem[rd_ptr];
  assign head_taken  = taken_mem[rd_ptr];

  assign pop = resolve_valid & ~empty;

  // A taken/taken pair still mispredicts when the predicted target was wrong.
  assign mispred = pop & ((head_taken != resolve_taken) |
                          (head_taken & resolve_taken & (head_target != resolve_target)));

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  // A push alongside a mispredict is wrong-path and is dropped.
  assign push_ok = pred_valid & (~full | pop) & ~mispred;

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr]     <= pred_pc;
      target_mem[wr_ptr] <= pred_target;
      taken_mem[wr_ptr]  <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      update_valid  <= 1'b0;
      update_taken  <= 1'b0;
      update_pc     <= '0;
    end else begin
      if (mispred) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end

      if (pred_valid && full && !pop) err_overflow  <= 1'b1;
      if (resolve_valid && empty)     err_underflow <= 1'b1;

      update_valid <= pop;
      update_taken <= pop & resolve_taken;
      update_pc    <= pop ? head_pc : '0;
      flush        <= mispred;
      if (pop) begin
        redirect_pc <= resolve_taken ? resolve_target : head_pc + ADDR_W'(4);
      end
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_cnt <= '0;
      mispred_cnt  <= '0;
    end else begin
      if (pop && resolved_cnt != 16'hFFFF)    resolved_cnt <= resolved_cnt + 16'd1;
      if (mispred && mispred_cnt != 16'hFFFF) mispred_cnt  <= mispred_cnt + 16'd1;
    end
  end
`else
  assign resolved_cnt = 16'h0000;
  assign mispred_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit

module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic        update_taken;
  logic [31:0] update_pc;
  logic        full;
  logic        empty;
  logic        err_overflow;
  logic        err_underflow;
  logic [15:0] resolved_cnt;
  logic [15:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_taken(update_taken), .update_pc(update_pc),
    .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pred_valid     = 1'b0;
    pred_taken     = 1'b0;
    pred_pc        = 32'h0;
    pred_target    = 32'h0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = 32'h0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    pred_valid  = 1'b1;
    pred_taken  = tk;
    pred_pc     = pc;
    pred_target = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    resolve_valid  = 1'b1;
    resolve_taken  = tk;
    resolve_target = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b exp 0", flush); end
    checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL reset_update_valid got %0b exp 0", update_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h exp 0", redirect_pc); end
    checks++; if (update_pc !== 32'h0) begin errors++; $display("FAIL reset_update_pc got %h exp 0", update_pc); end
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {err_overflow, err_underflow}); end
    checks++; if ({resolved_cnt, mispred_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", {resolved_cnt, mispred_cnt}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_correct;
    do_reset();
    push(32'h84, 1'b1, 32'h84);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL t1_not_empty got %0b exp 0", empty); end
    resolve(1'b1, 32'h84);
    checks++; if (update_valid !== 1'b1) begin errors++; $display("FAIL t1_update_valid got %0b exp 1", update_valid); end
    checks++; if (update_taken !== 1'b1) begin errors++; $display("FAIL t1_update_taken got %0b exp 1", update_taken); end
    checks++; if (update_pc !== 32'h84) begin errors++; $display("FAIL t1_update_pc got %h exp 84", update_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL t1_flush got %0b exp 0", flush); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t1_empty got %0b exp 1", empty); end
    tick();
    checks++; if ({update_valid, update_taken, flush} !== 3'b000) begin errors++; $display("FAIL t1_pulse_end got %b exp 000", {update_valid, update_taken, flush}); end
    checks++; if (update_pc !== 32'h0) begin errors++; $display("FAIL t1_update_pc_clear got %h exp 0", update_pc); end
  endtask

  task automatic test_mispred_not_taken;
    do_reset();
    push(32'h84, 1'b1, 32'h84);
    resolve(1'b0, 32'h0);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL t2_flush got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h88) begin errors++; $display("FAIL t2_redirect got %h exp 88", redirect_pc); end
    checks++; if (update_taken !== 1'b0) begin errors++; $display("FAIL t2_update_taken got %0b exp 0", update_taken); end
    checks++; if (update_valid !== 1'b1) begin errors++; $display("FAIL t2_update_valid got %0b exp 1", update_valid); end
`ifdef BRU_STATS_EN
    checks++; if (mispred_cnt !== 16'd1) begin errors++; $display("FAIL t2_mispred_cnt got %0d exp 1", mispred_cnt); end
    checks++; if (resolved_cnt !== 16'd1) begin errors++; $display("FAIL t2_resolved_cnt got %0d exp 1", resolved_cnt); end
`else
    checks++; if ({mispred_cnt, resolved_cnt} !== 32'h0) begin errors++; $display("FAIL t2_cnt_tied got %h exp 0", {mispred_cnt, resolved_cnt}); end
`endif
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL t2_flush_end got %0b exp 0", flush); end
    checks++; if (redirect_pc !== 32'h88) begin errors++; $display("FAIL t2_redirect_hold got %h exp 88", redirect_pc); end
  endtask

  task automatic test_mispred_target;
    do_reset();
    push(32'h100, 1'b0, 32'h0);
    resolve(1'b1, 32'h200);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL t3a_flush got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL t3a_redirect got %h exp 200", redirect_pc); end
    push(32'h104, 1'b1, 32'h140);
    resolve(1'b1, 32'h180);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL t3b_flush got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h180) begin errors++; $display("FAIL t3b_redirect got %h exp 180", redirect_pc); end
    checks++; if (update_pc !== 32'h104) begin errors++; $display("FAIL t3b_update_pc got %h exp 104", update_pc); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h14; exp_pc[1] = 32'h18; exp_pc[2] = 32'h1c; exp_pc[3] = 32'h20;
    do_reset();
    push(32'h10, 1'b0, 32'h0);
    push(32'h14, 1'b0, 32'h0);
    push(32'h18, 1'b0, 32'h0);
    push(32'h1c, 1'b0, 32'h0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL t4_full got %0b exp 1", full); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL t4_ovf_early got %0b exp 0", err_overflow); end
    push(32'h99, 1'b1, 32'h99);
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf got %0b exp 1", err_overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL t4_full_after_ovf got %0b exp 1", full); end
    pred_valid = 1'b1; pred_taken = 1'b0; pred_pc = 32'h20; pred_target = 32'h0;
    resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_target = 32'h0;
    tick();
    idle_inputs();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL t4_full_pushpop got %0b exp 1", full); end
    checks++; if (update_pc !== 32'h10) begin errors++; $display("FAIL t4_pushpop_pc got %h exp 10", update_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL t4_pushpop_flush got %0b exp 0", flush); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf_sticky got %0b exp 1", err_overflow); end
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (update_pc !== exp_pc[i] || update_valid !== 1'b1) begin errors++; $display("FAIL t4_drain%0d got pc %h v %0b exp pc %h v 1", i, update_pc, update_valid, exp_pc[i]); end
    end
    idle_inputs();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t4_drained_empty got %0b exp 1", empty); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL t4_no_underflow got %0b exp 0", err_underflow); end
`ifdef BRU_STATS_EN
    checks++; if (resolved_cnt !== 16'd5) begin errors++; $display("FAIL t4_resolved_cnt got %0d exp 5", resolved_cnt); end
`endif
  endtask

  task automatic test_flush_with_push;
    do_reset();
    push(32'h40, 1'b1, 32'h80);
    push(32'h44, 1'b0, 32'h0);
    push(32'h48, 1'b0, 32'h0);
    pred_valid = 1'b1; pred_taken = 1'b0; pred_pc = 32'h50; pred_target = 32'h0;
    resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_target = 32'h0;
    tick();
    idle_inputs();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL t5_flush got %0b exp 1", flush); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t5_empty got %0b exp 1", empty); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL t5_redirect got %h exp 44", redirect_pc); end
    resolve(1'b1, 32'h300);
    checks++; if ({update_valid, flush} !== 2'b00) begin errors++; $display("FAIL t5_underflow_outputs got %b exp 00", {update_valid, flush}); end
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL t5_underflow got %0b exp 1", err_underflow); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL t5_redirect_hold got %h exp 44", redirect_pc); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL t5_no_overflow got %0b exp 0", err_overflow); end
`ifdef BRU_STATS_EN
    checks++; if ({resolved_cnt, mispred_cnt} !== {16'd1, 16'd1}) begin errors++; $display("FAIL t5_cnt got %h exp 00010001", {resolved_cnt, mispred_cnt}); end
`endif
  endtask

  task automatic test_async_reset;
    do_reset();
    push(32'h60, 1'b0, 32'h0);
    push(32'h64, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    checks++; if ({update_valid, empty} !== 2'b10) begin errors++; $display("FAIL t6_pre got %b exp 10", {update_valid, empty}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t6_empty got %0b exp 1", empty); end
    checks++; if ({flush, update_valid} !== 2'b00) begin errors++; $display("FAIL t6_outputs got %b exp 00", {flush, update_valid}); end
    checks++; if (update_pc !== 32'h0) begin errors++; $display("FAIL t6_update_pc got %h exp 0", update_pc); end
    tick();
    rst_n = 1'b1;
    resolve(1'b0, 32'h0);
    checks++; if ({update_valid, err_underflow} !== 2'b01) begin errors++; $display("FAIL t6_entries_lost got %b exp 01", {update_valid, err_underflow}); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_correct();
    test_mispred_not_taken();
    test_mispred_target();
    test_back_to_back();
    test_flush_with_push();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
